// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic definitions for the NTT/FFT datapath.
// Used by the modular subtractor, the modular adder and the butterfly.
package mod_arith_pkg;

   localparam int DW     = 32;
   localparam int DW_EXT = DW + 1;

   typedef logic [DW-1:0]     data_t;
   typedef logic [DW_EXT-1:0] ext_t;

   // Stage-1 payload: the raw difference plus the modulus it must be folded with.
   typedef struct packed {
      data_t q;
      ext_t  diff;
   } sub_s1_t;

   // Fold a DW_EXT-bit difference back into [0, q): a set borrow bit means the
   // difference went negative, so adding q (mod 2^DW) restores the residue.
   function automatic data_t mod_fold(input ext_t diff, input data_t q);
      data_t res;
      if (diff[DW] == 1'b1) begin
         res = diff[DW-1:0] + q;
      end else begin
         res = diff[DW-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/sub_mod_stage_reg.sv
// Data + valid register slice with a shared enable.
// Valid follows upstream whenever enabled; data only moves on a valid transfer.
module sub_mod_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Valid bit: reloaded from upstream every enabled cycle, held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else if (en_i) begin
         valid_q <= valid_i;
      end else begin
         valid_q <= valid_q;
      end
   end

   // Payload: captured only when a valid item actually enters the slice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (en_i && valid_i) begin
         data_q <= data_i;
      end else begin
         data_q <= data_q;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/sub_mod_pipe.sv
// Two-stage pipelined modular subtractor: result = (a_in - b_in) mod q.
// Stage 1 forms the borrow-extended difference and snapshots q; stage 2 folds.
// Full valid/ready backpressure; the modulus register only loads when idle.
module sub_mod_pipe
   import mod_arith_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          q_load,
   input  logic [DW-1:0] q_in,
   output logic          q_busy,
   output logic          q_err,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] result
);

   logic    v1_s;
   logic    v2_s;
   logic    en1_s;
   logic    en2_s;
   sub_s1_t s1_d;
   sub_s1_t s1_q;
   data_t   s2_d;
   data_t   q_q;
   data_t   q_d;
   logic    q_err_q;
   logic    q_err_d;

   // Backpressure chain: a stage may load when it is empty or its consumer drains it.
   assign en2_s    = !v2_s || out_ready;
   assign en1_s    = !v1_s || en2_s;
   assign in_ready = en1_s;

   // Stage-1 payload: borrow-extended difference plus the modulus in force now,
   // so later modulus reloads never disturb in-flight pairs.
   always_comb begin
      s1_d      = '0;
      s1_d.q    = q_q;
      s1_d.diff = {1'b0, a_in} - {1'b0, b_in};
   end

   sub_mod_stage_reg #(
      .W($bits(sub_s1_t))
   ) u_stage1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en1_s),
      .valid_i (in_valid && en1_s),
      .data_i  (s1_d),
      .valid_o (v1_s),
      .data_o  (s1_q)
   );

   // Stage-2 payload: fold the negative differences back into [0, q).
   always_comb begin
      s2_d = '0;
      s2_d = mod_fold(s1_q.diff, s1_q.q);
   end

   sub_mod_stage_reg #(
      .W(DW)
   ) u_stage2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en2_s),
      .valid_i (v1_s),
      .data_i  (s2_d),
      .valid_o (v2_s),
      .data_o  (result)
   );

   assign out_valid = v2_s;

   // Any pending or arriving pair blocks a modulus change.
   assign q_busy = v1_s || v2_s || in_valid;

   // Modulus load decision: accept when idle, otherwise flag a sticky error.
   always_comb begin
      q_d     = q_q;
      q_err_d = q_err_q;
      if (q_load) begin
         if (!q_busy) begin
            q_d     = q_in;
            q_err_d = 1'b0;
         end else begin
            q_err_d = 1'b1;
         end
      end else begin
         q_d     = q_q;
         q_err_d = q_err_q;
      end
   end

   // Modulus and load-error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q     <= '0;
         q_err_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         q_err_q <= q_err_d;
      end
   end

   assign q_err = q_err_q;

endmodule

// File: tb/tb_sub_mod_pipe.sv
// Directed + scoreboard bench for sub_mod_pipe.
module tb_sub_mod_pipe;

   logic        clk;
   logic        rst_n;
   logic        q_load;
   logic [31:0] q_in;
   logic        q_busy;
   logic        q_err;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   longint unsigned q_model;
   longint unsigned exp_q[$];
   int              acc_cyc_q[$];
   longint unsigned got_q[$];
   int              cyc = 0;
   int              n_out = 0;
   bit              chk_lat = 1'b0;
   bit              hold_pending = 1'b0;
   logic [31:0]     held;
   bit              saw_ready_low = 1'b0;
   bit              rnd_done;

   sub_mod_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .q_load    (q_load),
      .q_in      (q_in),
      .q_busy    (q_busy),
      .q_err     (q_err),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned mod_sub(input longint unsigned a, input longint unsigned b,
                                               input longint unsigned q);
      return (a + q - b) % q;
   endfunction

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && !in_ready) saw_ready_low = 1'b1;
         if (in_valid && in_ready) begin
            exp_q.push_back(mod_sub(a_in, b_in, q_model));
            acc_cyc_q.push_back(cyc);
         end
         if (hold_pending) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", result, held);
         end
         hold_pending = out_valid && !out_ready;
         held = result;
         if (out_valid && out_ready) begin
            n_out++;
            got_q.push_back(result);
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               chk("result", result, exp_q.pop_front());
               if (chk_lat) chk("latency", cyc - acc_cyc_q.pop_front(), 2);
               else void'(acc_cyc_q.pop_front());
            end
         end
      end else begin
         hold_pending = 1'b0;
      end
   end

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
      int t;
      bit acc;
      in_valid = 1'b1;
      a_in = a;
      b_in = b;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) chk("push_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic load_q(input logic [31:0] v);
      q_load = 1'b1;
      q_in = v;
      @(posedge clk);
      #1;
      q_load = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 500) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n0;
      rst_n = 1'b0;
      q_load = 1'b0;
      q_in = 32'd0;
      in_valid = 1'b0;
      a_in = 32'd0;
      b_in = 32'd0;
      out_ready = 1'b1;
      q_model = 64'd97;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_q_err", q_err, 0);
      chk("rst_q_busy", q_busy, 0);
      chk("rst_result", result, 0);

      // Test 1: back-to-back, latency 2
      load_q(32'd97);
      chk("t1_q_err", q_err, 0);
      got_q.delete();
      chk_lat = 1'b1;
      push_pair(32'd10, 32'd3);
      push_pair(32'd3, 32'd10);
      push_pair(32'd0, 32'd96);
      drain();
      chk_lat = 1'b0;
      chk("t1_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("t1_r0", got_q[0], 7);
         chk("t1_r1", got_q[1], 90);
         chk("t1_r2", got_q[2], 1);
      end

      // Test 2: 8 pairs with a 3-cycle downstream stall
      n0 = n_out;
      saw_ready_low = 1'b0;
      fork
         for (int i = 0; i < 8; i++) push_pair(32'(i * 11 % 97), 32'(i * 29 % 97));
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      chk("t2_count", n_out - n0, 8);
      chk("t2_ready_dropped", saw_ready_low, 1);

      // Test 3: modulus near 2^32
      load_q(32'hFFFF_FFFB);
      q_model = 64'hFFFF_FFFB;
      got_q.delete();
      push_pair(32'd0, 32'hFFFF_FFFA);
      push_pair(32'hFFFF_FFFA, 32'd0);
      push_pair(32'd5, 32'd5);
      drain();
      chk("t3_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         chk("t3_r0", got_q[0], 1);
         chk("t3_r1", got_q[1], 64'hFFFF_FFFA);
         chk("t3_r2", got_q[2], 0);
      end

      // Test 4: rejected load while busy, accepted after drain
      load_q(32'd97);
      q_model = 64'd97;
      out_ready = 1'b0;
      push_pair(32'd1, 32'd2);
      push_pair(32'd3, 32'd4);
      chk("t4_v2_full", out_valid, 1);
      load_q(32'd13);
      chk("t4_q_err_set", q_err, 1);
      out_ready = 1'b1;
      drain();
      chk("t4_idle", q_busy, 0);
      chk("t4_q_err_sticky", q_err, 1);
      push_pair(32'd2, 32'd5);
      drain();
      chk("t4_q_kept", result, 94);
      load_q(32'd13);
      q_model = 64'd13;
      chk("t4_q_err_clr", q_err, 0);
      push_pair(32'd2, 32'd5);
      drain();
      chk("t4_new_q", result, 10);

      // Test 5: async reset mid-stream
      load_q(32'd97);
      q_model = 64'd97;
      out_ready = 1'b0;
      push_pair(32'd5, 32'd1);
      push_pair(32'd6, 32'd1);
      chk("t5_full", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_async_clear", out_valid, 0);
      exp_q.delete();
      acc_cyc_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("t5_in_ready", in_ready, 1);
      n0 = n_out;
      repeat (5) @(posedge clk);
      #1;
      chk("t5_no_stale", n_out - n0, 0);
      chk("t5_q_err_clr", q_err, 0);

      // Test 6: random stream with random backpressure
      load_q(32'd1000003);
      q_model = 64'd1000003;
      n0 = n_out;
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 10000; i++)
               push_pair(32'($urandom_range(0, 1000002)), 32'($urandom_range(0, 1000002)));
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();
      chk("t6_count", n_out - n0, 10000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
